pipe_opcode_sequencer: RTL and testbench

- Produces the per-stage opcode stream (ID/EX/MEM/WB) and the WB function code that the pipeline control decoder consumes.
- Holds the IF/ID, ID/EX, EX/MEM and MEM/WB instruction-tag registers.
- Detects load-use hazards and inserts bubbles, applies branch/jump flushes, and latches Halt, then drains the pipeline.

---
 rtl/pipe_opcode_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pipe_opcode_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_opcode_sequencer.sv
// Pipeline opcode sequencer: IF/ID, ID/EX, EX/MEM, MEM/WB instruction tags,
// load-use bubble insertion, branch/jump flush, and halt latch with drain.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   InstrIF          fetched instruction {opcode, op1, op2, function code}
//   InstrValid       InstrIF is valid this cycle
//   Flush            taken branch/jump resolved in ID, squash IF/ID
//   Opcode{ID,EX,MEM,WB}  per-stage opcode stream
//   FunctionCodeWB   function code of the WB-stage instruction
//   Op1ID, Op2ID     register fields of the ID-stage instruction
//   DestEX           op1 field of the EX-stage instruction
//   PCWrite          PC may advance
//   IFIDWrite        IF/ID register may load
//   Stall            load-use bubble inserted this cycle
//   Halted, Drained  sticky halt latched / halt reached WB
module pipe_opcode_sequencer #(
    parameter logic [3:0] NOP_OP  = 4'b0000,
    parameter logic [3:0] HALT_OP = 4'b0011,
    parameter logic [3:0] LBU_OP  = 4'b0100,
    parameter logic [3:0] LW_OP   = 4'b0110
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] InstrIF,
    input  logic        InstrValid,
    input  logic        Flush,
    output logic [3:0]  OpcodeID,
    output logic [3:0]  OpcodeEX,
    output logic [3:0]  OpcodeMEM,
    output logic [3:0]  OpcodeWB,
    output logic [3:0]  FunctionCodeWB,
    output logic [3:0]  Op1ID,
    output logic [3:0]  Op2ID,
    output logic [3:0]  DestEX,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        Stall,
    output logic        Halted,
    output logic        Drained
);

    // Field layout matches the instruction word so InstrIF maps directly.
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] op1;
        logic [3:0] op2;
        logic [3:0] fc;
    } stage_t;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    stage_t ifid_q, ifid_d;
    stage_t idex_q, idex_d;
    stage_t exmem_q, exmem_d;
    stage_t memwb_q, memwb_d;

    state_t     state_q;
    logic [1:0] cnt_q;
    logic       halted_q;
    logic       drained_q;

    logic       stall;
    logic       ld_ex;
    logic       dep;
    logic       halt_id;

    always_comb begin
        ld_ex = (idex_q.op == LBU_OP) || (idex_q.op == LW_OP);
        dep   = (idex_q.op1 == ifid_q.op1) ||
                (idex_q.op1 == ifid_q.op2);
        stall = ld_ex && dep && (ifid_q.op != NOP_OP);
        // A halt sitting behind a load-use hazard waits for the bubble.
        halt_id = (ifid_q.op == HALT_OP) && !stall;
    end

    always_comb begin
        ifid_d  = ifid_q;
        idex_d  = '0;
        exmem_d = idex_q;
        memwb_d = exmem_q;
        if (!stall) begin
            idex_d = ifid_q;
            if (halt_id || halted_q || Flush || !InstrValid) begin
                ifid_d = '0;
            end else begin
                ifid_d = stage_t'(InstrIF);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    // Halt/drain controller. The counter runs from the cycle after the
    // latch; by count 2 the halt opcode sits in MEM/WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RUN;
            cnt_q     <= 2'd0;
            halted_q  <= 1'b0;
            drained_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (halt_id) begin
                        state_q  <= S_DRAIN;
                        halted_q <= 1'b1;
                        cnt_q    <= 2'd0;
                    end
                end
                S_DRAIN: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd2 && memwb_q.op == HALT_OP) begin
                        state_q   <= S_DONE;
                        drained_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (cnt_q != 2'd3) begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    assign OpcodeID       = ifid_q.op;
    assign Op1ID          = ifid_q.op1;
    assign Op2ID          = ifid_q.op2;
    assign OpcodeEX       = idex_q.op;
    assign DestEX         = idex_q.op1;
    assign OpcodeMEM      = exmem_q.op;
    assign OpcodeWB       = memwb_q.op;
    assign FunctionCodeWB = memwb_q.fc;
    assign Stall          = stall;
    assign Halted         = halted_q;
    assign Drained        = drained_q;
    assign PCWrite        = !stall && !halted_q;
    assign IFIDWrite      = !stall && !halted_q;

endmodule

// File: tb/tb_pipe_opcode_sequencer.sv
// Directed bench for pipe_opcode_sequencer: vector table plus hand
// sequences for halt-behind-stall and asynchronous reset.
module tb_pipe_opcode_sequencer;

    logic        clk;
    logic        rst;
    logic [15:0] InstrIF;
    logic        InstrValid;
    logic        Flush;
    logic [3:0]  OpcodeID, OpcodeEX, OpcodeMEM, OpcodeWB;
    logic [3:0]  FunctionCodeWB, Op1ID, Op2ID, DestEX;
    logic        PCWrite, IFIDWrite, Stall, Halted, Drained;

    int n_cmp = 0;
    int n_err = 0;

    pipe_opcode_sequencer dut (
        .clk(clk), .rst(rst),
        .InstrIF(InstrIF), .InstrValid(InstrValid), .Flush(Flush),
        .OpcodeID(OpcodeID), .OpcodeEX(OpcodeEX),
        .OpcodeMEM(OpcodeMEM), .OpcodeWB(OpcodeWB),
        .FunctionCodeWB(FunctionCodeWB),
        .Op1ID(Op1ID), .Op2ID(Op2ID), .DestEX(DestEX),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .Stall(Stall),
        .Halted(Halted), .Drained(Drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] instr;
        logic        valid;
        logic        flush;
        logic [3:0]  id;
        logic [3:0]  ex;
        logic [3:0]  mem;
        logic [3:0]  wb;
        logic [3:0]  fc;
        logic [3:0]  dest;
        logic        stall;
        logic        pcw;
        logic        halted;
        logic        drained;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic add(input logic [15:0] ins, input logic v,
                       input logic f, input logic [3:0] id,
                       input logic [3:0] ex, input logic [3:0] mem,
                       input logic [3:0] wb, input logic [3:0] fc,
                       input logic [3:0] dest, input logic st,
                       input logic pcw, input logic h, input logic d);
        vq.push_back({ins, v, f, id, ex, mem, wb, fc, dest,
                      st, pcw, h, d});
    endtask

    task automatic step(input logic [15:0] ins, input logic v,
                        input logic f);
        @(negedge clk);
        InstrIF    = ins;
        InstrValid = v;
        Flush      = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        InstrIF = '0;
        InstrValid = 1'b0;
        Flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        InstrIF = '0;
        InstrValid = 1'b0;
        Flush = 1'b0;
        #12;
        chk("rst.id", {12'h0, OpcodeID}, 16'h0);
        chk("rst.ex", {12'h0, OpcodeEX}, 16'h0);
        chk("rst.mem", {12'h0, OpcodeMEM}, 16'h0);
        chk("rst.wb", {12'h0, OpcodeWB}, 16'h0);
        chk("rst.fc", {12'h0, FunctionCodeWB}, 16'h0);
        chk("rst.ctl", {11'h0, Stall, PCWrite, IFIDWrite, Halted,
                        Drained}, 16'b0_1100);
        @(negedge clk);
        rst = 1'b0;

        //   instr    v  f  id   ex   mem  wb   fc   dst st pw h  d
        add(16'h1123,1,0,4'h1,4'h0,4'h0,4'h0,4'h0,4'h0,0,1,0,0);
        add(16'h9450,1,0,4'h9,4'h1,4'h0,4'h0,4'h0,4'h1,0,1,0,0);
        add(16'hA670,1,0,4'hA,4'h9,4'h1,4'h0,4'h0,4'h4,0,1,0,0);
        add(16'h0000,0,0,4'h0,4'hA,4'h9,4'h1,4'h3,4'h6,0,1,0,0);
        add(16'h0000,0,0,4'h0,4'h0,4'hA,4'h9,4'h0,4'h0,0,1,0,0);
        add(16'h0000,0,0,4'h0,4'h0,4'h0,4'hA,4'h0,4'h0,0,1,0,0);
        add(16'h6210,1,0,4'h6,4'h0,4'h0,4'h0,4'h0,4'h0,0,1,0,0);
        add(16'h1325,1,0,4'h1,4'h6,4'h0,4'h0,4'h0,4'h2,1,0,0,0);
        add(16'h0000,0,0,4'h1,4'h0,4'h6,4'h0,4'h0,4'h0,0,1,0,0);
        add(16'h0000,0,0,4'h0,4'h1,4'h0,4'h6,4'h0,4'h3,0,1,0,0);
        add(16'h0000,0,0,4'h0,4'h0,4'h1,4'h0,4'h0,4'h0,0,1,0,0);
        add(16'h0000,0,0,4'h0,4'h0,4'h0,4'h1,4'h5,4'h0,0,1,0,0);
        add(16'h6210,1,0,4'h6,4'h0,4'h0,4'h0,4'h0,4'h0,0,1,0,0);
        add(16'h1345,1,0,4'h1,4'h6,4'h0,4'h0,4'h0,4'h2,0,1,0,0);
        add(16'h0000,0,0,4'h0,4'h1,4'h6,4'h0,4'h0,4'h3,0,1,0,0);
        add(16'hC120,1,0,4'hC,4'h0,4'h1,4'h6,4'h0,4'h0,0,1,0,0);
        add(16'h1111,1,1,4'h0,4'hC,4'h0,4'h1,4'h5,4'h1,0,1,0,0);
        add(16'h0000,0,0,4'h0,4'h0,4'hC,4'h0,4'h0,4'h0,0,1,0,0);
        add(16'h0000,0,0,4'h0,4'h0,4'h0,4'hC,4'h0,4'h0,0,1,0,0);
        add(16'h3000,1,0,4'h3,4'h0,4'h0,4'h0,4'h0,4'h0,0,1,0,0);
        add(16'h1111,1,0,4'h0,4'h3,4'h0,4'h0,4'h0,4'h0,0,0,1,0);
        add(16'h1222,1,0,4'h0,4'h0,4'h3,4'h0,4'h0,4'h0,0,0,1,0);
        add(16'h1333,1,0,4'h0,4'h0,4'h0,4'h3,4'h0,4'h0,0,0,1,0);
        add(16'h1444,1,0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0,0,1,1);
        add(16'h1555,1,1,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,0,0,1,1);

        foreach (vq[i]) begin
            vec_t v;
            v = vq[i];
            step(v.instr, v.valid, v.flush);
            chk($sformatf("v%0d.id", i), {12'h0, OpcodeID}, {12'h0, v.id});
            chk($sformatf("v%0d.ex", i), {12'h0, OpcodeEX}, {12'h0, v.ex});
            chk($sformatf("v%0d.mem", i), {12'h0, OpcodeMEM},
                {12'h0, v.mem});
            chk($sformatf("v%0d.wb", i), {12'h0, OpcodeWB}, {12'h0, v.wb});
            chk($sformatf("v%0d.fc", i), {12'h0, FunctionCodeWB},
                {12'h0, v.fc});
            chk($sformatf("v%0d.dest", i), {12'h0, DestEX},
                {12'h0, v.dest});
            chk($sformatf("v%0d.ctl", i),
                {11'h0, Stall, PCWrite, IFIDWrite, Halted, Drained},
                {11'h0, v.stall, v.pcw, v.pcw, v.halted, v.drained});
        end

        // Async reset clears sticky Halted/Drained without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("arst.hd", {14'h0, Halted, Drained}, 16'h0);
        chk("arst.pcw", {14'h0, PCWrite, IFIDWrite}, 16'h3);
        @(negedge clk);
        rst = 1'b0;

        // Halt behind a load-use hazard waits one bubble before latching.
        step(16'h6210, 1'b1, 1'b0);
        step(16'h3210, 1'b1, 1'b0);
        chk("hs.stall", {15'h0, Stall}, 16'h1);
        chk("hs.ops", {8'h0, Op1ID, Op2ID}, 16'h0021);
        chk("hs.h0", {15'h0, Halted}, 16'h0);
        step(16'h1777, 1'b1, 1'b0);
        chk("hs.id", {12'h0, OpcodeID}, 16'h3);
        chk("hs.ex", {12'h0, OpcodeEX}, 16'h0);
        chk("hs.h1", {15'h0, Halted}, 16'h0);
        step(16'h1777, 1'b1, 1'b0);
        chk("hs.h2", {14'h0, Halted, PCWrite}, 16'h2);
        chk("hs.id2", {12'h0, OpcodeID, OpcodeEX}, 16'h03);

        // Async reset while a stall is active.
        do_reset();
        step(16'h6210, 1'b1, 1'b0);
        step(16'h1325, 1'b1, 1'b0);
        chk("rs.stall", {15'h0, Stall}, 16'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rs.ops", {OpcodeID, OpcodeEX, OpcodeMEM, OpcodeWB}, 16'h0);
        chk("rs.ctl", {13'h0, Stall, PCWrite, Halted}, 16'b010);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
